alias_out_serializer: RTL and testbench

- Downstream consumer of the 128-bit aliased output bus produced by the alias test stage.
- Accepts one full 128-bit word per valid/ready handshake and emits it as DATA_W/BEAT_W narrower beats, least-significant beat first, each with valid/ready flow control.
- Sits between the aliased-output stage and the cosim capture/trace logic, so the wide result can be streamed and compared beat by beat.

---
 rtl/alias_ser_pkg.sv | 22 ++
 rtl/ser_beat_counter.sv | 38 +++
 rtl/alias_out_serializer.sv | 81 ++++++++
 tb/tb_alias_out_serializer.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/alias_ser_pkg.sv
// Shared types, default widths and the beat-slice helper for the aliased-output serializer.
package alias_ser_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } ser_state_e;

    localparam int DEF_DATA_W = 128;
    localparam int DEF_BEAT_W = 32;
    localparam int MAX_DATA_W = 1024;

    // Caller zero-extends its buffer to MAX_DATA_W and truncates the result to its beat width.
    function automatic logic [MAX_DATA_W-1:0] beat_slice(
        input logic [MAX_DATA_W-1:0] word,
        input int unsigned           idx,
        input int unsigned           beat_w
    );
        return word >> (idx * beat_w);
    endfunction

endpackage

// File: rtl/ser_beat_counter.sv
// Beat index counter: clear has priority, advance steps by one and saturates at NBEATS-1.
// Registered index, combinational last flag.
module ser_beat_counter #(
    parameter int NBEATS = 4,
    parameter int IDX_W  = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear_i,
    input  logic             advance_i,
    output logic [IDX_W-1:0] idx_o,
    output logic             last_o
);

    logic [IDX_W-1:0] idx_q;
    logic [IDX_W-1:0] idx_d;

    assign last_o = (idx_q == IDX_W'(NBEATS - 1));
    assign idx_o  = idx_q;

    always_comb begin
        idx_d = idx_q;
        if (clear_i) begin
            idx_d = '0;
        end else if (advance_i && !last_o) begin
            idx_d = idx_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx_q <= '0;
        end else begin
            idx_q <= idx_d;
        end
    end

endmodule

// File: rtl/alias_out_serializer.sv
// Splits each DATA_W word into NBEATS beats, LSB first; beat 0 appears the cycle after capture.
// Stalled beats hold; a new word is taken on the last-beat handshake so words stream without bubbles.
module alias_out_serializer
    import alias_ser_pkg::*;
#(
    parameter  int DATA_W = DEF_DATA_W,
    parameter  int BEAT_W = DEF_BEAT_W,
    localparam int NBEATS = DATA_W / BEAT_W,
    localparam int IDX_W  = $clog2(NBEATS)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [BEAT_W-1:0] out_data,
    output logic [IDX_W-1:0]  out_idx,
    output logic              out_last,
    output logic              busy
);

    ser_state_e        state_q, state_d;
    logic [DATA_W-1:0] buf_q, buf_d;
    logic [IDX_W-1:0]  cnt_idx;
    logic              cnt_last;
    logic              in_hs;
    logic              beat_hs;
    logic              last_hs;

    assign out_valid = (state_q == SEND);
    assign busy      = out_valid;
    assign out_idx   = cnt_idx;
    assign out_last  = out_valid && cnt_last;
    assign beat_hs   = out_valid && out_ready;
    assign last_hs   = beat_hs && cnt_last;
    assign in_ready  = (state_q == IDLE) || last_hs;
    assign in_hs     = in_valid && in_ready;

    // Gated so the stale buffer never shows on out_data while idle.
    assign out_data = out_valid
                    ? BEAT_W'(beat_slice(MAX_DATA_W'(buf_q), 32'(cnt_idx), BEAT_W))
                    : '0;

    ser_beat_counter #(
        .NBEATS (NBEATS),
        .IDX_W  (IDX_W)
    ) u_cnt (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear_i   (in_hs || last_hs),
        .advance_i (beat_hs),
        .idx_o     (cnt_idx),
        .last_o    (cnt_last)
    );

    always_comb begin
        state_d = state_q;
        buf_d   = buf_q;
        if (in_hs) begin
            buf_d = in_data;
        end
        case (state_q)
            IDLE:    if (in_hs) state_d = SEND;
            SEND:    if (last_hs && !in_valid) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            buf_q   <= '0;
        end else begin
            state_q <= state_d;
            buf_q   <= buf_d;
        end
    end

endmodule

// File: tb/tb_alias_out_serializer.sv
// Directed and randomized checks of alias_out_serializer beat ordering, flow control and reset.
module tb_alias_out_serializer;

    localparam int DATA_W = 128;
    localparam int BEAT_W = 32;
    localparam int NBEATS = 4;
    localparam int IDX_W  = 2;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic              out_valid;
    logic              out_ready;
    logic [BEAT_W-1:0] out_data;
    logic [IDX_W-1:0]  out_idx;
    logic              out_last;
    logic              busy;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    alias_out_serializer #(.DATA_W(DATA_W), .BEAT_W(BEAT_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_idx   (out_idx),
        .out_last  (out_last),
        .busy      (busy)
    );

    // {valid, idx, last, busy, in_ready, data}
    wire [37:0] obs = {out_valid, out_idx, out_last, busy, in_ready, out_data};

    function automatic logic [37:0] ev(input logic v, input int idx, input logic last,
                                       input logic bsy, input logic rdy, input logic [31:0] d);
        return {v, 2'(idx), last, bsy, rdy, d};
    endfunction

    function automatic logic [31:0] beat(input logic [127:0] w, input int b);
        return w[b*32 +: 32];
    endfunction

    localparam logic [37:0] IDLE_OBS = {1'b0, 2'd0, 1'b0, 1'b0, 1'b1, 32'h0};

    task automatic test_reset();
        rst_n = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
        #12;
        n_checks++;
        if (obs !== IDLE_OBS) $display("FAIL reset_outputs got=%h exp=%h", obs, IDLE_OBS);
        else n_pass++;
        @(negedge clk); rst_n = 1'b1;
        @(negedge clk);
        n_checks++;
        if (obs !== IDLE_OBS) $display("FAIL post_reset_idle got=%h exp=%h", obs, IDLE_OBS);
        else n_pass++;
    endtask

    task automatic test_single();
        logic [127:0] w = 128'h33333333_22222222_11111111_00000000;
        logic [37:0]  e;
        @(posedge clk); #1;
        in_valid = 1'b1; in_data = w; out_ready = 1'b1;
        @(negedge clk);
        n_checks++;
        if (obs !== IDLE_OBS) $display("FAIL single_accept got=%h exp=%h", obs, IDLE_OBS);
        else n_pass++;
        @(posedge clk); #1;
        in_valid = 1'b0; in_data = '0;
        for (int b = 0; b < NBEATS; b++) begin
            @(negedge clk);
            e = ev(1'b1, b, b == 3, 1'b1, b == 3, beat(w, b));
            n_checks++;
            if (obs !== e) $display("FAIL single_beat%0d got=%h exp=%h", b, obs, e);
            else n_pass++;
        end
        @(negedge clk);
        n_checks++;
        if (obs !== IDLE_OBS) $display("FAIL single_idle got=%h exp=%h", obs, IDLE_OBS);
        else n_pass++;
    endtask

    task automatic test_back_to_back();
        logic [127:0] wa = {32'h3, 32'h2, 32'h1, 32'h0};
        logic [127:0] wb = {32'hDDDDDDDD, 32'hCCCCCCCC, 32'hBBBBBBBB, 32'hAAAAAAAA};
        logic [37:0]  e;
        @(posedge clk); #1;
        in_valid = 1'b1; in_data = wa; out_ready = 1'b1;
        @(negedge clk);
        n_checks++;
        if (obs !== IDLE_OBS) $display("FAIL b2b_accept got=%h exp=%h", obs, IDLE_OBS);
        else n_pass++;
        @(posedge clk); #1;
        in_data = wb;
        for (int b = 0; b < 2 * NBEATS; b++) begin
            @(negedge clk);
            e = ev(1'b1, b % 4, (b % 4) == 3, 1'b1, (b % 4) == 3,
                   (b < 4) ? beat(wa, b) : beat(wb, b - 4));
            n_checks++;
            if (obs !== e) $display("FAIL b2b_beat%0d got=%h exp=%h", b, obs, e);
            else n_pass++;
            if (b == 3) begin
                @(posedge clk); #1;
                in_valid = 1'b0; in_data = '0;
            end
        end
        @(negedge clk);
        n_checks++;
        if (obs !== IDLE_OBS) $display("FAIL b2b_idle got=%h exp=%h", obs, IDLE_OBS);
        else n_pass++;
    endtask

    task automatic test_backpressure();
        logic [127:0] w = 128'hCAFE0003_CAFE0002_CAFE0001_CAFE0000;
        logic         rdy[7] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
        int           idx[7] = '{0, 1, 1, 1, 1, 2, 3};
        logic [37:0]  e;
        @(posedge clk); #1;
        in_valid = 1'b1; in_data = w; out_ready = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0; in_data = '0;
        for (int c = 0; c < 7; c++) begin
            out_ready = rdy[c];
            @(negedge clk);
            e = ev(1'b1, idx[c], idx[c] == 3, 1'b1, (idx[c] == 3) && rdy[c], beat(w, idx[c]));
            n_checks++;
            if (obs !== e) $display("FAIL stall_cycle%0d got=%h exp=%h", c, obs, e);
            else n_pass++;
            @(posedge clk); #1;
        end
        @(negedge clk);
        n_checks++;
        if (obs !== IDLE_OBS) $display("FAIL stall_idle got=%h exp=%h", obs, IDLE_OBS);
        else n_pass++;
    endtask

    task automatic test_data_ignore();
        logic [127:0] w = 128'h89ABCDEF_01234567_DEADBEEF_5A5A5A5A;
        logic [37:0]  e;
        @(posedge clk); #1;
        in_valid = 1'b1; in_data = w; out_ready = 1'b1;
        for (int b = 0; b < NBEATS; b++) begin
            @(posedge clk); #1;
            in_valid = (b != 3);
            in_data  = (b % 2 == 0) ? {DATA_W{1'b1}} : {DATA_W{1'b0}};
            @(negedge clk);
            e = ev(1'b1, b, b == 3, 1'b1, b == 3, beat(w, b));
            n_checks++;
            if (obs !== e) $display("FAIL ignore_beat%0d got=%h exp=%h", b, obs, e);
            else n_pass++;
        end
        @(posedge clk); #1;
        in_data = '0;
        @(negedge clk);
        n_checks++;
        if (obs !== IDLE_OBS) $display("FAIL ignore_idle got=%h exp=%h", obs, IDLE_OBS);
        else n_pass++;
    endtask

    task automatic test_async_reset();
        logic [127:0] w = 128'h44444444_33333333_22222222_11111111;
        logic [37:0]  e;
        @(posedge clk); #1;
        in_valid = 1'b1; in_data = w; out_ready = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0; in_data = '0;
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        e = ev(1'b1, 2, 1'b0, 1'b1, 1'b0, beat(w, 2));
        n_checks++;
        if (obs !== e) $display("FAIL areset_pre got=%h exp=%h", obs, e);
        else n_pass++;
        #2 rst_n = 1'b0;
        #1;
        n_checks++;
        if (obs !== IDLE_OBS) $display("FAIL areset_immediate got=%h exp=%h", obs, IDLE_OBS);
        else n_pass++;
        @(posedge clk); #2;
        rst_n = 1'b1;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            n_checks++;
            if (obs !== IDLE_OBS) $display("FAIL areset_after%0d got=%h exp=%h", c, obs, IDLE_OBS);
            else n_pass++;
        end
    endtask

    task automatic test_random();
        logic [127:0] q[$];
        logic [127:0] asm_w = '0;
        logic [127:0] exp_w;
        int           accepted = 0;
        int           received = 0;
        int           cycles   = 0;
        int           exp_idx  = 0;
        bit           idx_ok   = 1'b1;
        while (received < 1000 && cycles < 30000) begin
            @(posedge clk); #1;
            in_valid  = (accepted < 1000) && ($urandom_range(1) == 1);
            in_data   = {$urandom, $urandom, $urandom, $urandom};
            out_ready = ($urandom_range(1) == 1);
            @(negedge clk);
            cycles++;
            if (in_valid && in_ready) begin
                q.push_back(in_data);
                accepted++;
            end
            if (out_valid && out_ready) begin
                if (out_idx !== 2'(exp_idx) || out_last !== (exp_idx == 3)) idx_ok = 1'b0;
                asm_w[exp_idx*32 +: 32] = out_data;
                if (exp_idx == 3) begin
                    exp_w = (q.size() > 0) ? q.pop_front() : {DATA_W{1'bx}};
                    n_checks++;
                    if (asm_w !== exp_w || !idx_ok)
                        $display("FAIL rand_word%0d got=%h exp=%h idx_ok=%0d",
                                 received, asm_w, exp_w, idx_ok);
                    else n_pass++;
                    received++;
                    exp_idx = 0;
                    idx_ok  = 1'b1;
                end else begin
                    exp_idx++;
                end
            end
        end
        in_valid = 1'b0; out_ready = 1'b1;
        n_checks++;
        if (received != 1000 || q.size() != 0)
            $display("FAIL rand_totals received=%0d exp=1000 leftover=%0d exp=0", received, q.size());
        else n_pass++;
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_backpressure();
        test_data_ignore();
        test_async_reset();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
